// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - byte-serial AES SubBytes using one external combinational sbox
module sub_bytes_seq #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic [7:0]             sbox_data_in,
    input  logic [7:0]             sbox_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    // One extra counter bit keeps the post-terminal value distinct from byte 0.
    localparam int CW = $clog2(NUM_BYTES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [8*NUM_BYTES-1:0]   cap;

    // Present the captured byte selected by cnt to the sbox while running; zero otherwise.
    always_comb begin
        sbox_data_in = 8'h00;
        if (state == RUN) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (cnt == i[CW-1:0]) begin
                    sbox_data_in = cap[8*NUM_BYTES-1-8*i -: 8];
                end
            end
        end
    end

    // Control FSM: capture block, substitute one byte per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        cap      <= in_data;
                        cnt      <= '0;
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (cnt == i[CW-1:0]) begin
                            out_data[8*NUM_BYTES-1-8*i -: 8] <= sbox_data_out;
                        end
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - randomized self-checking bench for sub_bytes_seq
module tb_sub_bytes_seq;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [7:0]   sbox_data_in;
    logic [7:0]   sbox_data_out;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;

    logic [7:0]   sbox_tab [256];

    int pass_cnt = 0;
    int total_cnt = 0;

    sub_bytes_seq #(.NUM_BYTES(NB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sbox_data_in  (sbox_data_in),
        .sbox_data_out (sbox_data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External combinational sbox
    assign sbox_data_out = sbox_tab[sbox_data_in];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] byte_of(input logic [W-1:0] d, input int i);
        return d[W-1-8*i -: 8];
    endfunction

    // Reference: apply the AES sbox to every byte independently
    function automatic logic [W-1:0] model(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[W-1-8*i -: 8] = sbox_tab[byte_of(d, i)];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_block();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] av, bv, inv;
        for (int a = 0; a < 256; a++) begin
            av = a[7:0];
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                bv = b[7:0];
                if (av != 8'h00 && gmul(av, bv) == 8'h01) inv = bv;
            end
            sbox_tab[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic accept(input logic [W-1:0] d);
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (busy) nbusy++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (sbox_data_in !== 8'h00) $display("FAIL reset_sbox_in: got %h want 00", sbox_data_in); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_known_vector();
        int n, nb;
        accept(128'h00112233445566778899aabbccddeeff);
        wait_valid(n, nb);
        total_cnt++; if (n !== 17) $display("FAIL kv_latency: got %0d want 17", n); else pass_cnt++;
        total_cnt++; if (out_data !== 128'h638293c31bfc33f5c4eeacea4bc12816)
            $display("FAIL kv_out_data: got %h want 638293c31bfc33f5c4eeacea4bc12816", out_data); else pass_cnt++;
        total_cnt++; if (sbox_data_in !== 8'h00) $display("FAIL kv_sbox_in_done: got %h want 00", sbox_data_in); else pass_cnt++;
        release_out();
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL kv_out_valid_drop: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL kv_in_ready_rise: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_busy_c2();
        int n, nb;
        accept({NB{8'hc2}});
        wait_valid(n, nb);
        total_cnt++; if (nb !== 16) $display("FAIL c2_busy_cycles: got %0d want 16", nb); else pass_cnt++;
        total_cnt++; if (out_data !== {NB{8'h25}}) $display("FAIL c2_out_data: got %h want all 25", out_data); else pass_cnt++;
        release_out();
    endtask

    task automatic test_random_bytes();
        logic [W-1:0] d;
        int errs;
        for (int b = 0; b < 3; b++) begin
            d = rand_block();
            errs = 0;
            accept(d);
            for (int k = 0; k < NB; k++) begin
                @(negedge clk);
                if (sbox_data_in !== byte_of(d, k) || busy !== 1'b1) errs++;
            end
            total_cnt++; if (errs != 0) $display("FAIL rnd_sbox_addr: got %0d bad cycles want 0", errs); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b1 || out_data !== model(d))
                $display("FAIL rnd_result: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, model(d)); else pass_cnt++;
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d, snap;
        int n, nb, errs;
        d = rand_block();
        snap = model(d);
        accept(d);
        wait_valid(n, nb);
        total_cnt++; if (out_data !== snap) $display("FAIL bp_result: got %h want %h", out_data, snap); else pass_cnt++;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) errs++;
            in_valid = 1'b1;
            in_data = rand_block();
        end
        total_cnt++; if (errs != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", errs); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== snap) $display("FAIL bp_retain: got %h want %h", out_data, snap); else pass_cnt++;
    endtask

    task automatic test_ignore_in_valid();
        logic [W-1:0] d1;
        d1 = rand_block();
        accept(d1);
        for (int k = 1; k <= NB; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 1);
            in_data = rand_block();
        end
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== model(d1))
            $display("FAIL ign_result: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, model(d1)); else pass_cnt++;
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int n, nb;
        accept(rand_block());
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_mid_ctrl: got busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL rst_mid_out_data: got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (sbox_data_in !== 8'h00) $display("FAIL rst_mid_sbox_in: got %h want 00", sbox_data_in); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_mid_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
        accept('0);
        wait_valid(n, nb);
        total_cnt++; if (n !== 17) $display("FAIL rst_zero_latency: got %0d want 17", n); else pass_cnt++;
        total_cnt++; if (out_data !== {NB{8'h63}}) $display("FAIL rst_zero_result: got %h want all 63", out_data); else pass_cnt++;
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] blocks [4];
        logic [W-1:0] got [$];
        int acc [$];
        int cyc, idx, errs;
        logic take;
        for (int i = 0; i < 4; i++) blocks[i] = rand_block();
        @(negedge clk);
        out_ready = 1'b1;
        in_data = blocks[0];
        in_valid = 1'b1;
        idx = 0;
        cyc = 0;
        while (cyc < 4 * 18 + 40) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (out_valid) got.push_back(out_data);
            take = in_valid && in_ready;
            if (take) acc.push_back(cyc);
            @(posedge clk);
            #1;
            if (take) begin
                idx++;
                if (idx < 4) in_data = blocks[idx];
                else in_valid = 1'b0;
            end
            if (got.size() == 4) break;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (got.size() != 4) $display("FAIL b2b_count: got %0d results want 4", got.size()); else pass_cnt++;
        errs = 0;
        for (int i = 0; i < got.size() && i < 4; i++) if (got[i] !== model(blocks[i])) errs++;
        total_cnt++; if (errs != 0) $display("FAIL b2b_data: got %0d wrong results want 0", errs); else pass_cnt++;
        errs = 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 18) errs++;
        total_cnt++; if (errs != 0 || acc.size() != 4)
            $display("FAIL b2b_spacing: got %0d bad gaps over %0d accepts want 0 over 4", errs, acc.size()); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        build_sbox();
        test_reset();
        test_known_vector();
        test_busy_c2();
        test_random_bytes();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
